// File: rtl/p12_cfg_seq.sv
// p12_cfg_seq: configuration sequencer for the rotating-tile fabric.
// Shifts CHAIN_LEN command bits into the tile scan chain, pulses the selected
// v/h/d latch enables for the first half of one cycle, then drops the
// loop-breaker hold.
// Optional feature: define P12_CFG_READBACK_EN to stream the previous chain
// contents out on rd_valid/rd_data while a new load shifts in.
module p12_cfg_seq #(
  parameter int CHAIN_LEN = 144
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       bit_data,
  input  logic       scan_in,
  output logic       scan_se,
  output logic       scan_sc,
  output logic       lat_v,
  output logic       lat_h,
  output logic       lat_d,
  output logic       lb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rd_valid,
  output logic       rd_data
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // registered outputs and their next values
  logic se_q, se_nxt;
  logic bit_ready_q, bit_ready_nxt;
  logic cmd_ready_q, cmd_ready_nxt;
  logic busy_q, busy_nxt;
  logic done_q, done_nxt;
  logic lb_q, lb_nxt;
  logic err_q;

  // latch-enable half-cycle pulse: posedge flop AND NOT negedge copy
  logic [2:0] lat_p, lat_p_nxt, lat_n;

  assign accept = (state == IDLE) && cmd_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; a missing bit in SHIFT aborts straight back to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (!bit_valid)        state_nxt = IDLE;
        else if (cnt_q == LAST) state_nxt = LATCH;
      end
      LATCH:   state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs, decoded from the next state
  always_comb begin
    se_nxt        = (state_nxt == SHIFT) || (state_nxt == LATCH);
    bit_ready_nxt = (state_nxt == SHIFT);
    cmd_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == RELEASE);
    lat_p_nxt     = (state_nxt == LATCH) ? sel_q : 3'b000;
    lb_nxt        = lb_q;
    if (accept)                       lb_nxt = 1'b1;
    else if (state_nxt == RELEASE)    lb_nxt = 1'b0;
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      se_q        <= 1'b0;
      bit_ready_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lb_q        <= 1'b1;
      lat_p       <= 3'b000;
    end else begin
      se_q        <= se_nxt;
      bit_ready_q <= bit_ready_nxt;
      cmd_ready_q <= cmd_ready_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      lb_q        <= lb_nxt;
      lat_p       <= lat_p_nxt;
    end
  end

  // command capture, shift counter and sticky underrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 3'b000;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      sel_q <= cmd_sel;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state == SHIFT) begin
      if (bit_valid) cnt_q <= cnt_q + CNT_W'(1);
      else           err_q <= 1'b1;
    end
  end

  // negedge copy closes the latch pulse halfway through the LATCH cycle
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) lat_n <= 3'b000;
    else        lat_n <= lat_p;
  end

  // scan data: config bit while shifting, recirculate during LATCH, else 0
  always_comb begin
    scan_sc = 1'b0;
    if (state == SHIFT)      scan_sc = bit_valid & bit_data;
    else if (state == LATCH) scan_sc = scan_in;
  end

`ifdef P12_CFG_READBACK_EN
  logic rd_valid_q, rd_data_q;

  // capture the chain tail on every accepted shift cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 1'b0;
    end else begin
      rd_valid_q <= (state == SHIFT) && bit_valid;
      if ((state == SHIFT) && bit_valid) rd_data_q <= scan_in;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  assign rd_valid = 1'b0;
  assign rd_data  = 1'b0;
`endif

  assign {lat_v, lat_h, lat_d} = lat_p & ~lat_n;
  assign scan_se   = se_q;
  assign bit_ready = bit_ready_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lb        = lb_q;
  assign err       = err_q;

endmodule

// File: tb/tb_p12_cfg_seq.sv
// Bench for p12_cfg_seq with an 8-flop tile chain model on the scan nets.
module tb_p12_cfg_seq;
  localparam int N = 8;

  logic clk, rst_n;
  logic cmd_valid, cmd_ready, bit_valid, bit_ready, bit_data;
  logic [2:0] cmd_sel;
  logic scan_in, scan_se, scan_sc, lat_v, lat_h, lat_d, lb, busy, done, err;
  logic rd_valid, rd_data;

  p12_cfg_seq #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .bit_data(bit_data), .scan_in(scan_in), .scan_se(scan_se),
    .scan_sc(scan_sc), .lat_v(lat_v), .lat_h(lat_h), .lat_d(lat_d),
    .lb(lb), .busy(busy), .done(done), .err(err),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // tile chain model: chain[0] is the first tile, chain[N-1] feeds scan_in
  logic [N-1:0] chain = '0;
  assign scan_in = chain[N-1];
  always @(posedge clk) if (scan_se === 1'b1) chain <= {chain[N-2:0], scan_sc};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int v_rise, h_rise, d_rise;
  always @(posedge lat_v) v_rise++;
  always @(posedge lat_h) h_rise++;
  always @(posedge lat_d) d_rise++;

  int checks = 0, errors = 0;
  int exp_done_q[$];
  int se_cnt, done_cnt, lat_late;
  logic [N-1:0] chain_snap;
  logic [2:0] lat_snap;
  logic err_first;
`ifdef P12_CFG_READBACK_EN
  logic rb_q[$];
  logic [N-1:0] rd_vec;
`else
  int rd_bad;
`endif

  // drive one command; drop_at = SHIFT cycle with bit_valid low (0 = none)
  task automatic run_cmd(input logic [2:0] sel, input logic [N-1:0] bits, input int drop_at);
    int e;
    logic r;
    se_cnt = 0; done_cnt = 0; lat_late = 0; v_rise = 0; h_rise = 0; d_rise = 0;
    chain_snap = '0; lat_snap = 3'b000; err_first = 1'bx;
`ifdef P12_CFG_READBACK_EN
    rd_vec = '0;
`else
    rd_bad = 0;
`endif
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_at_accept: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_sel = sel;
    if (drop_at == 0) exp_done_q.push_back(cyc + N + 2);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_sel = ~sel;   // must be ignored after acceptance
    for (int j = 1; j <= N + 2; j++) begin
      if (j == 1) err_first = err;
      if (scan_se === 1'b1) se_cnt++;
      if (done === 1'b1) begin
        done_cnt++; checks++;
        if (exp_done_q.size() == 0) begin
          errors++; $display("FAIL done_unexpected: done=1 at cycle %0d, none expected", cyc);
        end else begin
          e = exp_done_q.pop_front();
          if (cyc !== e) begin
            errors++; $display("FAIL done_latency: done at cycle %0d want %0d", cyc, e);
          end
        end
      end
      if (j == N + 1) begin chain_snap = chain; lat_snap = {lat_v, lat_h, lat_d}; end
`ifdef P12_CFG_READBACK_EN
      if (rd_valid === 1'b1) begin
        rd_vec = {rd_vec[N-2:0], rd_data};
        checks++;
        if (rb_q.size() == 0) begin
          errors++; $display("FAIL rd_unexpected: rd_valid=1 with nothing pending");
        end else begin
          r = rb_q.pop_front();
          if (rd_data !== r) begin
            errors++; $display("FAIL rd_data: got %b want %b", rd_data, r);
          end
        end
      end
`else
      r = 1'b0;
      if (rd_valid !== r || rd_data !== r) rd_bad++;
`endif
      if (j <= N && (drop_at == 0 || j < drop_at)) begin
        bit_valid = 1'b1; bit_data = bits[N-j];
`ifdef P12_CFG_READBACK_EN
        rb_q.push_back(chain[N-1]);
`endif
      end else if (j == drop_at) begin
        bit_valid = 1'b0; bit_data = 1'b1;
        #1; checks++;
        if (scan_sc !== 1'b0) begin
          errors++; $display("FAIL underrun_scan_sc: got %b want 0", scan_sc);
        end
      end else begin
        bit_valid = 1'b0; bit_data = 1'b0;
      end
      if (drop_at != 0 && j == drop_at + 1) begin
        checks++;
        if ({busy, cmd_ready, err, lb} !== 4'b0111) begin
          errors++; $display("FAIL underrun_idle: busy,ready,err,lb=%b want 0111", {busy, cmd_ready, err, lb});
        end
      end
      @(negedge clk); #1;
      if ((lat_v | lat_h | lat_d) !== 1'b0) lat_late++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_sel = 3'b000; bit_valid = 1'b0; bit_data = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({scan_se, scan_sc, lat_v, lat_h, lat_d} !== 5'b00000) begin
      errors++; $display("FAIL reset_scan: se,sc,v,h,d=%b want 00000", {scan_se, scan_sc, lat_v, lat_h, lat_d});
    end
    checks++;
    if ({lb, cmd_ready, bit_ready, busy} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctl: lb,cmd_ready,bit_ready,busy=%b want 1100", {lb, cmd_ready, bit_ready, busy});
    end
    checks++;
    if ({done, err, rd_valid, rd_data} !== 4'b0000) begin
      errors++; $display("FAIL reset_status: done,err,rd_valid,rd_data=%b want 0000", {done, err, rd_valid, rd_data});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({lb, cmd_ready, busy} !== 3'b110) begin
      errors++; $display("FAIL reset_release: lb,cmd_ready,busy=%b want 110", {lb, cmd_ready, busy});
    end
  endtask

  task automatic test_load_v();
    run_cmd(3'b100, 8'hB2, 0);
    checks++;
    if (se_cnt !== N + 1) begin errors++; $display("FAIL v_scan_se_cycles: got %0d want %0d", se_cnt, N + 1); end
    checks++;
    if ({v_rise, h_rise, d_rise} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL v_pulses: v,h,d rises=%0d,%0d,%0d want 1,0,0", v_rise, h_rise, d_rise);
    end
    checks++;
    if (lat_snap !== 3'b100 || lat_late !== 0) begin
      errors++; $display("FAIL v_half_cycle: latch=%b late=%0d want 100 and 0", lat_snap, lat_late);
    end
    checks++;
    if (chain_snap !== 8'hB2) begin errors++; $display("FAIL v_chain: got %h want b2", chain_snap); end
    checks++;
    if (done_cnt !== 1 || lb !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL v_finish: done_cnt=%0d lb=%b err=%b want 1,0,0", done_cnt, lb, err);
    end
  endtask

  task automatic test_load_hd();
    run_cmd(3'b011, 8'h5C, 0);
    checks++;
    if ({v_rise, h_rise, d_rise} !== {32'd0, 32'd1, 32'd1} || lat_snap !== 3'b011) begin
      errors++; $display("FAIL hd_pulses: v,h,d rises=%0d,%0d,%0d latch=%b want 0,1,1 011", v_rise, h_rise, d_rise, lat_snap);
    end
    checks++;
    if (chain_snap !== 8'h5C || lb !== 1'b0 || done_cnt !== 1) begin
      errors++; $display("FAIL hd_finish: chain=%h lb=%b done_cnt=%0d want 5c,0,1", chain_snap, lb, done_cnt);
    end
  endtask

  task automatic test_shift_only();
    run_cmd(3'b000, 8'hE7, 0);
    checks++;
    if ((v_rise + h_rise + d_rise) !== 0 || lat_snap !== 3'b000) begin
      errors++; $display("FAIL shift_only_lat: rises=%0d latch=%b want 0 000", v_rise + h_rise + d_rise, lat_snap);
    end
    checks++;
    if (done_cnt !== 1 || lb !== 1'b0 || se_cnt !== N + 1) begin
      errors++; $display("FAIL shift_only_finish: done_cnt=%0d lb=%b se=%0d want 1,0,%0d", done_cnt, lb, se_cnt, N + 1);
    end
  endtask

  task automatic test_underrun();
    run_cmd(3'b111, 8'hFF, 5);
    checks++;
    if ((v_rise + h_rise + d_rise) !== 0 || done_cnt !== 0) begin
      errors++; $display("FAIL underrun_quiet: rises=%0d done_cnt=%0d want 0,0", v_rise + h_rise + d_rise, done_cnt);
    end
    checks++;
    if (se_cnt !== 5 || err !== 1'b1 || lb !== 1'b1) begin
      errors++; $display("FAIL underrun_state: se=%0d err=%b lb=%b want 5,1,1", se_cnt, err, lb);
    end
    run_cmd(3'b010, 8'h3A, 0);
    checks++;
    if (err_first !== 1'b0 || err !== 1'b0 || h_rise !== 1 || lb !== 1'b0) begin
      errors++; $display("FAIL underrun_recover: err1=%b err=%b h=%0d lb=%b want 0,0,1,0", err_first, err, h_rise, lb);
    end
  endtask

  task automatic test_reset_mid_shift();
    cmd_valid = 1'b1; cmd_sel = 3'b101;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      bit_valid = 1'b1; bit_data = j[0];
      @(posedge clk); #1;
    end
    bit_valid = 1'b1; bit_data = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scan_se, busy, bit_ready, lb, cmd_ready} !== 5'b00011) begin
      errors++; $display("FAIL mid_reset: se,busy,bit_ready,lb,cmd_ready=%b want 00011", {scan_se, busy, bit_ready, lb, cmd_ready});
    end
    bit_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(3'b111, 8'h96, 0);
    checks++;
    if ({v_rise, h_rise, d_rise} !== {32'd1, 32'd1, 32'd1} || chain_snap !== 8'h96 || lb !== 1'b0) begin
      errors++; $display("FAIL mid_reset_recover: rises=%0d,%0d,%0d chain=%h lb=%b want 1,1,1 96 0", v_rise, h_rise, d_rise, chain_snap, lb);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(3'b100, 8'hB2, 0);
    checks++;
    if (chain_snap !== 8'hB2 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_first: chain=%h done_cnt=%0d want b2,1", chain_snap, done_cnt);
    end
    run_cmd(3'b001, 8'h0F, 0);
    checks++;
    if (chain_snap !== 8'h0F || d_rise !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL b2b_second: chain=%h d=%0d done_cnt=%0d want 0f,1,1", chain_snap, d_rise, done_cnt);
    end
`ifdef P12_CFG_READBACK_EN
    // LATCH recirculates once, so the stream starts at the second bit of the
    // first load and ends with its first bit
    checks++;
    if (rd_vec !== 8'h65) begin errors++; $display("FAIL b2b_readback: got %h want 65", rd_vec); end
    checks++;
    if (rb_q.size() != 0) begin errors++; $display("FAIL b2b_rd_left: %0d bits never read back", rb_q.size()); end
`else
    checks++;
    if (rd_bad !== 0) begin errors++; $display("FAIL rd_tied_off: %0d cycles with rd activity want 0", rd_bad); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_v();
    test_load_hd();
    test_shift_only();
    test_underrun();
    test_reset_mid_shift();
    test_back_to_back();
    checks++;
    if (exp_done_q.size() != 0) begin
      errors++; $display("FAIL done_missing: %0d expected done pulses not seen", exp_done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
